// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared stream types and defaults for the axis blocks
package axis_pkg;

  localparam int AXIS_DATA_W = 32;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - one-entry ready/valid register; loads while empty or draining
module axis_reg_slice
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  // Load and drain can coincide, giving one beat per cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_data  <= in_data;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_rr_merge.sv
// rtl/axis_rr_merge.sv - round-robin merge of lanes into one packet with generated TLAST
module axis_rr_merge
  import axis_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = AXIS_DATA_W,
  parameter int LEN_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [DATA_W-1:0] INPUT_AXIS_TDATA  [0:NUM_LANES-1],
  input  logic              INPUT_AXIS_TLAST  [0:NUM_LANES-1],
  input  logic              INPUT_AXIS_TVALID [0:NUM_LANES-1],
  output logic              INPUT_AXIS_TREADY [0:NUM_LANES-1],
  output logic [DATA_W-1:0] OUTPUT_AXIS_TDATA,
  output logic              OUTPUT_AXIS_TLAST,
  output logic              OUTPUT_AXIS_TVALID,
  input  logic              OUTPUT_AXIS_TREADY,
  input  logic              err_clr,
  output logic              tlast_err
);

  localparam int PTR_W = $clog2(NUM_LANES);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_LANES - 1);
  localparam logic [LEN_W:0] LANES_EXT = (LEN_W + 1)'(NUM_LANES);

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cur_len;
  logic [DATA_W-1:0] lane_data;
  logic              lane_valid;
  logic              lane_last;
  logic              slice_ready;
  logic              accept;
  logic              is_last;
  logic              exp_last;

  // The packet length is live only on the opening beat; afterwards the latched copy rules.
  always_comb begin
    cur_len    = (state == ST_IDLE) ? ((pkt_len == '0) ? LEN_W'(1) : pkt_len) : len_q;
    lane_data  = INPUT_AXIS_TDATA[ptr];
    lane_valid = INPUT_AXIS_TVALID[ptr];
    lane_last  = INPUT_AXIS_TLAST[ptr];
    is_last    = (cnt == cur_len - LEN_W'(1));
    exp_last   = ({1'b0, cnt} + LANES_EXT) >= {1'b0, cur_len};
    accept     = !rst && slice_ready && lane_valid;
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      INPUT_AXIS_TREADY[i] = !rst && (ptr == PTR_W'(i)) && slice_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      tlast_err <= 1'b0;
    end else begin
      // A fresh mismatch beats a simultaneous clear.
      if (accept && (lane_last != exp_last)) begin
        tlast_err <= 1'b1;
      end else if (err_clr) begin
        tlast_err <= 1'b0;
      end

      if (accept) begin
        if (state == ST_IDLE) begin
          len_q <= cur_len;
        end
        if (is_last) begin
          state <= ST_IDLE;
          ptr   <= '0;
          cnt   <= '0;
        end else begin
          state <= ST_RUN;
          ptr   <= (ptr == PTR_MAX) ? '0 : ptr + PTR_W'(1);
          cnt   <= cnt + LEN_W'(1);
        end
      end
    end
  end

  axis_reg_slice #(
    .DATA_W(DATA_W)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .in_data  (lane_data),
    .in_last  (is_last),
    .in_valid (accept),
    .in_ready (slice_ready),
    .out_data (OUTPUT_AXIS_TDATA),
    .out_last (OUTPUT_AXIS_TLAST),
    .out_valid(OUTPUT_AXIS_TVALID),
    .out_ready(OUTPUT_AXIS_TREADY)
  );

endmodule

// File: tb/tb_axis_rr_merge.sv
// tb/tb_axis_rr_merge.sv - randomized bench for axis_rr_merge against a packet-level model
module tb_axis_rr_merge;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 16;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] pkt_len;
  logic [DW-1:0] in_data  [0:N-1];
  logic          in_last  [0:N-1];
  logic          in_valid [0:N-1];
  logic          in_ready [0:N-1];
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          err_clr;
  logic          tlast_err;

  int    n_assert = 0;
  int    n_fail   = 0;
  beat_t lane_q [0:N-1][$];
  beat_t exp_q  [$];
  logic  err_model;
  int    cycles;

  always #5 clk = ~clk;

  axis_rr_merge #(
    .NUM_LANES(N),
    .DATA_W   (DW),
    .LEN_W    (LW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pkt_len           (pkt_len),
    .INPUT_AXIS_TDATA  (in_data),
    .INPUT_AXIS_TLAST  (in_last),
    .INPUT_AXIS_TVALID (in_valid),
    .INPUT_AXIS_TREADY (in_ready),
    .OUTPUT_AXIS_TDATA (out_data),
    .OUTPUT_AXIS_TLAST (out_last),
    .OUTPUT_AXIS_TVALID(out_valid),
    .OUTPUT_AXIS_TREADY(out_ready),
    .err_clr           (err_clr),
    .tlast_err         (tlast_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negative edge; holds rst for one rising edge.
  task automatic do_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b1;
      in_last[i]  = 1'b0;
      in_data[i]  = $urandom;
    end
    #1;
    for (int i = 0; i < N; i++) check("ready_in_reset", in_ready[i], 1'b0);
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_err", tlast_err, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0;
      lane_q[i].delete();
    end
    exp_q.delete();
    err_model = 1'b0;
  endtask

  // Plays one packet of L beats through the lanes and checks it beat by beat.
  // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random. vld_mode: 0 always valid, 1 random.
  task automatic run_packet(input int L, input bit rand_data, input int ready_mode,
                            input int vld_mode, input int err_lane, input int hold_lane,
                            input int abort_at, output int cyc);
    int    le;
    int    j;
    int    hold_left;
    bit    hold_done;
    int    ptr_m;
    bit    can_load;
    bit    acc;
    bit    bad;
    beat_t b;
    le        = (L < 1) ? 1 : L;
    j         = 0;
    cyc       = 0;
    hold_left = 0;
    hold_done = 0;
    for (int i = 0; i < N; i++) begin
      int n_i;
      n_i = (le > i) ? (le - 1 - i) / N + 1 : 0;
      for (int k = 0; k < n_i; k++) begin
        b.data = rand_data ? DW'($urandom) : DW'(100 * i + k);
        b.last = (k == n_i - 1);
        if (i == err_lane && k == 0) b.last = !b.last;
        lane_q[i].push_back(b);
      end
    end
    pkt_len = LW'(L);
    while (!(j == le && exp_q.size() == 0) && cyc < 2000) begin
      @(negedge clk);
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("out_data", out_data, exp_q[0].data);
        check("out_last", out_last, exp_q[0].last);
      end
      check("tlast_err", tlast_err, err_model);
      if (abort_at >= 0 && j == abort_at) break;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (j > 0) pkt_len = LW'($urandom);
      if (hold_lane >= 0 && !hold_done && j == 1) begin
        hold_left = 5;
        hold_done = 1;
      end
      for (int i = 0; i < N; i++) begin
        in_valid[i] = (lane_q[i].size() != 0) && (vld_mode == 0 || $urandom_range(0, 3) != 0);
        if (i == hold_lane && hold_left > 0) in_valid[i] = 1'b0;
        if (lane_q[i].size() != 0) begin
          in_data[i] = lane_q[i][0].data;
          in_last[i] = lane_q[i][0].last;
        end else begin
          in_data[i] = $urandom;
          in_last[i] = 1'($urandom_range(0, 1));
        end
      end
      if (hold_left > 0) hold_left--;
      ptr_m    = (j < le) ? j % N : 0;
      can_load = (exp_q.size() == 0) || out_ready;
      #1;
      for (int i = 0; i < N; i++) check("in_ready", in_ready[i], (i == ptr_m) && can_load);
      if ((exp_q.size() != 0) && out_ready) void'(exp_q.pop_front());
      acc = (j < le) && in_valid[ptr_m] && can_load;
      if (acc) begin
        b   = lane_q[ptr_m].pop_front();
        bad = (b.last != (j + N >= le));
        exp_q.push_back('{last: (j == le - 1), data: b.data});
        j++;
      end else begin
        bad = 0;
      end
      if (bad) err_model = 1'b1;
      else if (err_clr) err_model = 1'b0;
      cyc++;
    end
    if (abort_at < 0) check("pkt_complete", cyc < 2000, 1'b1);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr   = 1'b0;
    err_model = 1'b0;
    check("err_cleared", tlast_err, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    pkt_len   = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    err_model = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_data[i]  = '0;
      in_last[i]  = 1'b0;
      in_valid[i] = 1'b0;
    end
    @(negedge clk);
    do_reset();

    run_packet(8, 0, 0, 0, -1, -1, -1, cycles);
    check("full_throughput_cycles", cycles, 9);
    run_packet(6, 0, 0, 0, -1, -1, -1, cycles);
    run_packet(8, 1, 1, 0, -1, -1, -1, cycles);
    run_packet(8, 1, 0, 0, -1, 1, -1, cycles);

    run_packet(8, 1, 0, 0, 2, -1, -1, cycles);
    check("err_sticky", tlast_err, 1'b1);
    clear_err();

    err_clr = 1'b1;
    run_packet(8, 1, 0, 0, 2, -1, -1, cycles);
    err_clr = 1'b0;
    check("err_clr_held", tlast_err, 1'b0);

    for (int p = 0; p < 24; p++) begin
      run_packet($urandom_range(0, 13), 1, $urandom_range(0, 2), $urandom_range(0, 1),
                 $urandom_range(0, 7), -1, -1, cycles);
      clear_err();
    end

    run_packet(8, 1, 0, 0, -1, -1, 3, cycles);
    do_reset();
    run_packet(1, 1, 2, 1, -1, -1, -1, cycles);
    run_packet(0, 1, 0, 0, -1, -1, -1, cycles);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
